// File: rtl/move_history.sv
// Move log for a board game: circular buffer of recent moves with a registered
// random-access read port and a multi-cycle "undo back to player X" sequencer.
module move_history #(
    parameter int COORD_W  = 3,
    parameter int DEPTH    = 64,
    parameter int PLAYER_W = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [COORD_W-1:0]         i_row,
    input  logic [COORD_W-1:0]         i_col,
    input  logic [PLAYER_W-1:0]        i_player,
    input  logic                       i_pass,
    input  logic                       i_undo,
    input  logic [PLAYER_W-1:0]        i_undo_player,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
    output logic                       o_rd_valid,
    output logic [COORD_W-1:0]         o_rd_row,
    output logic [COORD_W-1:0]         o_rd_col,
    output logic [PLAYER_W-1:0]        o_rd_player,
    output logic                       o_rd_pass,
    output logic                       o_pop_valid,
    output logic [COORD_W-1:0]         o_pop_row,
    output logic [COORD_W-1:0]         o_pop_col,
    output logic [PLAYER_W-1:0]        o_pop_player,
    output logic                       o_pop_pass,
    output logic                       o_busy,
    output logic                       o_undo_done,
    output logic                       o_undo_fail,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_wrapped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [COORD_W-1:0]  row;
        logic [COORD_W-1:0]  col;
        logic [PLAYER_W-1:0] player;
        logic                pass;
    } entry_t;

    typedef enum logic [1:0] {IDLE, POP, FIN} state_t;

    state_t              state, state_nxt;
    entry_t              mem [DEPTH];
    logic [AW-1:0]       wr_ptr, wr_ptr_nxt, pop_addr, rd_addr;
    logic [CW-1:0]       count_nxt;
    logic [PLAYER_W-1:0] undo_player_q;
    entry_t              wr_entry, pop_entry, rd_entry;
    logic                push_acc, undo_acc, pop_match, pop_last, rd_valid_nxt;

    always_comb begin
        push_acc         = i_push && !i_undo && !i_clear && (state == IDLE);
        undo_acc         = i_undo && !i_clear && (state == IDLE);
        wr_entry.row     = i_pass ? '0 : i_row;
        wr_entry.col     = i_pass ? '0 : i_col;
        wr_entry.player  = i_player;
        wr_entry.pass    = i_pass;
        pop_addr         = wr_ptr - AW'(1);
        pop_entry        = mem[pop_addr];
        pop_match        = (pop_entry.player == undo_player_q);
        pop_last         = (o_count == CW'(1));
    end

    // Pointer/count after this edge; the read port addresses from these so a
    // same-edge push or pop is already visible (write-first).
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        count_nxt  = o_count;
        if (i_clear) begin
            wr_ptr_nxt = '0;
            count_nxt  = '0;
        end else if (push_acc) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
            if (o_count != FULL)
                count_nxt = o_count + CW'(1);
        end else if (state == POP) begin
            wr_ptr_nxt = pop_addr;
            count_nxt  = o_count - CW'(1);
        end
        rd_addr      = wr_ptr_nxt - AW'(1) - i_rd_idx;
        rd_entry     = (push_acc && (rd_addr == wr_ptr)) ? wr_entry : mem[rd_addr];
        rd_valid_nxt = ({1'b0, i_rd_idx} < count_nxt);
    end

    always_ff @(posedge i_clk) begin
        if (push_acc)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (undo_acc && (o_count != '0)) state_nxt = POP;
                POP:     if (pop_match || pop_last)       state_nxt = FIN;
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy = (state != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr        <= '0;
            o_count       <= '0;
            o_wrapped     <= 1'b0;
            undo_player_q <= '0;
            o_pop_valid   <= 1'b0;
            o_pop_row     <= '0;
            o_pop_col     <= '0;
            o_pop_player  <= '0;
            o_pop_pass    <= 1'b0;
            o_undo_done   <= 1'b0;
            o_undo_fail   <= 1'b0;
            o_rd_valid    <= 1'b0;
            o_rd_row      <= '0;
            o_rd_col      <= '0;
            o_rd_player   <= '0;
            o_rd_pass     <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            o_count      <= count_nxt;
            o_pop_valid  <= 1'b0;
            o_pop_row    <= '0;
            o_pop_col    <= '0;
            o_pop_player <= '0;
            o_pop_pass   <= 1'b0;
            o_undo_done  <= 1'b0;
            o_undo_fail  <= 1'b0;
            if (i_clear) begin
                o_wrapped <= 1'b0;
            end else begin
                if (push_acc && (o_count == FULL))
                    o_wrapped <= 1'b1;
                if (undo_acc) begin
                    undo_player_q <= i_undo_player;
                    if (o_count == '0)
                        o_undo_fail <= 1'b1;
                end
                if (state == POP) begin
                    o_pop_valid  <= 1'b1;
                    o_pop_row    <= pop_entry.row;
                    o_pop_col    <= pop_entry.col;
                    o_pop_player <= pop_entry.player;
                    o_pop_pass   <= pop_entry.pass;
                    if (pop_match)
                        o_undo_done <= 1'b1;
                    else if (pop_last)
                        o_undo_fail <= 1'b1;
                end
            end
            o_rd_valid  <= rd_valid_nxt;
            o_rd_row    <= rd_valid_nxt ? rd_entry.row    : '0;
            o_rd_col    <= rd_valid_nxt ? rd_entry.col    : '0;
            o_rd_player <= rd_valid_nxt ? rd_entry.player : '0;
            o_rd_pass   <= rd_valid_nxt ? rd_entry.pass   : 1'b0;
        end
    end

endmodule

// File: tb/tb_move_history.sv
// Directed bench for move_history: per-cycle vector table on a DEPTH=64 instance,
// plus hand sequences for reset, wrap-around (DEPTH=4) and reset mid-undo.
module tb_move_history;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0, push = 1'b0, pass = 1'b0, undo = 1'b0;
    logic [2:0] row = '0, col = '0;
    logic       player = 1'b0, undo_player = 1'b0;
    logic [5:0] rd_idx = '0;
    logic [1:0] rd_idx4 = '0;

    logic       rd_valid, rd_player, rd_pass, pop_valid, pop_player, pop_pass;
    logic       busy, done, fail, wrapped;
    logic [2:0] rd_row, rd_col, pop_row, pop_col;
    logic [6:0] count;

    logic       rd_valid4, rd_player4, rd_pass4, pop_valid4, pop_player4, pop_pass4;
    logic       busy4, done4, fail4, wrapped4;
    logic [2:0] rd_row4, rd_col4, pop_row4, pop_col4;
    logic [2:0] count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    move_history #(.COORD_W(3), .DEPTH(64), .PLAYER_W(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_push(push),
        .i_row(row), .i_col(col), .i_player(player), .i_pass(pass),
        .i_undo(undo), .i_undo_player(undo_player), .i_rd_idx(rd_idx),
        .o_rd_valid(rd_valid), .o_rd_row(rd_row), .o_rd_col(rd_col),
        .o_rd_player(rd_player), .o_rd_pass(rd_pass),
        .o_pop_valid(pop_valid), .o_pop_row(pop_row), .o_pop_col(pop_col),
        .o_pop_player(pop_player), .o_pop_pass(pop_pass),
        .o_busy(busy), .o_undo_done(done), .o_undo_fail(fail),
        .o_count(count), .o_wrapped(wrapped)
    );

    move_history #(.COORD_W(3), .DEPTH(4), .PLAYER_W(1)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_push(push),
        .i_row(row), .i_col(col), .i_player(player), .i_pass(pass),
        .i_undo(undo), .i_undo_player(undo_player), .i_rd_idx(rd_idx4),
        .o_rd_valid(rd_valid4), .o_rd_row(rd_row4), .o_rd_col(rd_col4),
        .o_rd_player(rd_player4), .o_rd_pass(rd_pass4),
        .o_pop_valid(pop_valid4), .o_pop_row(pop_row4), .o_pop_col(pop_col4),
        .o_pop_player(pop_player4), .o_pop_pass(pop_pass4),
        .o_busy(busy4), .o_undo_done(done4), .o_undo_fail(fail4),
        .o_count(count4), .o_wrapped(wrapped4)
    );

    typedef struct {
        logic        clr, psh, pl, ps, und, upl;
        logic [2:0]  r, c;
        logic [5:0]  idx;
        logic [27:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int clr_i, psh_i, r_i, c_i, pl_i, ps_i, und_i, upl_i, idx_i,
                                input int b, pv, pr, pc, pp, pps, d, f, n, rv, rr, rc, rp, rps);
        vec_t v;
        v.clr = 1'(clr_i); v.psh = 1'(psh_i); v.r = 3'(r_i); v.c = 3'(c_i);
        v.pl = 1'(pl_i); v.ps = 1'(ps_i); v.und = 1'(und_i); v.upl = 1'(upl_i);
        v.idx = 6'(idx_i);
        v.exp = {1'(b), 1'(pv), 3'(pr), 3'(pc), 1'(pp), 1'(pps), 1'(d), 1'(f),
                 7'(n), 1'(rv), 3'(rr), 3'(rc), 1'(rp), 1'(rps)};
        return v;
    endfunction

    function automatic logic [27:0] observed();
        return {busy, pop_valid, pop_row, pop_col, pop_player, pop_pass, done, fail,
                count, rd_valid, rd_row, rd_col, rd_player, rd_pass};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        clear = 0; push = 0; pass = 0; undo = 0; row = 0; col = 0;
        player = 0; undo_player = 0; rd_idx = 0; rd_idx4 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // args: clr,push,row,col,pl,pass,undo,upl,idx | busy,pv,prow,pcol,ppl,ppass,done,fail,count,rv,rrow,rcol,rpl,rpass
        // undo back to player 0: one pop, done
        vecs.push_back(mk(0,1,2,3,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,1,2,3,0,0));
        vecs.push_back(mk(0,1,4,5,1,0,0,0,0, 0,0,0,0,0,0,0,0,2,1,4,5,1,0));
        vecs.push_back(mk(0,1,1,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,3,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,0,0, 1,0,0,0,0,0,0,0,3,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,1,1,0,0,1,0,2,1,4,5,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,2,1,4,5,1,0));
        // undo back to player 1: two pops, three busy cycles
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,2,3,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,1,2,3,0,0));
        vecs.push_back(mk(0,1,4,5,1,0,0,0,0, 0,0,0,0,0,0,0,0,2,1,4,5,1,0));
        vecs.push_back(mk(0,1,1,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,3,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,1,0, 1,0,0,0,0,0,0,0,3,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,1,1,0,0,0,0,2,1,4,5,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,4,5,1,0,1,0,1,1,2,3,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,1,2,3,0,0));
        // undo with no matching entry empties the log; undo on empty fails at once
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,0,0, 0,0,0,0,0,0,0,0,1,1,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,0,0, 1,0,0,0,0,0,0,0,1,1,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,0,0,1,0,0,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        // pass move: coordinates stored as zero
        vecs.push_back(mk(0,1,7,6,1,1,0,0,0, 0,0,0,0,0,0,0,0,1,1,0,0,1,1));
        vecs.push_back(mk(0,0,0,0,0,0,1,1,0, 1,0,0,0,0,0,0,0,1,1,0,0,1,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,0,0,1,1,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        // push+undo together, push while busy, clear mid-pop
        vecs.push_back(mk(0,1,1,2,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,1,1,2,0,0));
        vecs.push_back(mk(0,1,3,4,1,0,0,0,0, 0,0,0,0,0,0,0,0,2,1,3,4,1,0));
        vecs.push_back(mk(0,1,5,6,0,0,0,0,0, 0,0,0,0,0,0,0,0,3,1,5,6,0,0));
        vecs.push_back(mk(0,1,7,7,1,0,1,1,0, 1,0,0,0,0,0,0,0,3,1,5,6,0,0));
        vecs.push_back(mk(0,1,7,7,0,0,0,0,0, 1,1,5,6,0,0,0,0,2,1,3,4,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        // read index boundaries during an undo; undo during FIN is ignored
        vecs.push_back(mk(0,1,1,2,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,1,1,2,0,0));
        vecs.push_back(mk(0,1,3,4,1,0,0,0,1, 0,0,0,0,0,0,0,0,2,1,1,2,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,2, 0,0,0,0,0,0,0,0,2,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,0,1, 1,0,0,0,0,0,0,0,2,1,1,2,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 1,1,3,4,1,0,0,0,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 1,1,1,2,0,0,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0));

        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        chk("reset_outputs", {36'd0, observed()}, 64'd0);
        chk("reset_wrapped", {62'd0, wrapped, wrapped4}, 64'd0);
        rst_n = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            clear = vecs[i].clr; push = vecs[i].psh; row = vecs[i].r; col = vecs[i].c;
            player = vecs[i].pl; pass = vecs[i].ps; undo = vecs[i].und;
            undo_player = vecs[i].upl; rd_idx = vecs[i].idx;
            tick();
            chk($sformatf("vec%0d", i), {36'd0, observed()}, {36'd0, vecs[i].exp});
        end

        // wrap-around on the DEPTH=4 instance: rows 0..5 pushed
        idle_inputs();
        clear = 1;
        tick();
        clear = 0;
        for (int i = 0; i < 6; i++) begin
            push = 1; row = 3'(i);
            tick();
            chk($sformatf("wrap_count%0d", i), 64'(count4), (i < 4) ? 64'(i + 1) : 64'd4);
            chk($sformatf("wrap_flag%0d", i), 64'(wrapped4), (i >= 4) ? 64'd1 : 64'd0);
        end
        push = 0; row = 0;
        chk("deep_count", 64'(count), 64'd6);
        chk("deep_wrapped", 64'(wrapped), 64'd0);
        rd_idx4 = 2'd3;
        tick();
        chk("wrap_rd_oldest", {60'd0, rd_valid4, rd_row4}, {60'd0, 1'b1, 3'd2});
        rd_idx4 = 2'd0;
        tick();
        chk("wrap_rd_newest", {60'd0, rd_valid4, rd_row4}, {60'd0, 1'b1, 3'd5});

        // reset in the middle of an undo: no pulse, everything cleared
        idle_inputs();
        clear = 1;
        tick();
        clear = 0;
        push = 1; row = 3'd1; col = 3'd1;
        tick();
        push = 0;
        undo = 1; undo_player = 1;
        tick();
        undo = 0;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 0;
        tick();
        chk("reset_mid_pop", {61'd0, busy, done, fail}, 64'd0);
        chk("reset_mid_pop_pop", {36'd0, observed()}, 64'd0);
        rst_n = 1;
        tick();
        chk("after_reset_quiet", {36'd0, observed()}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
